// File: rtl/fp_int_to_float_seq.sv
// fp_int_to_float_seq
// Multi-cycle converter from a 32-bit integer to an IEEE-754 single-precision float.
// Normalisation shifts the magnitude left by one bit per cycle until bit 31 is set.
// A single rounding cycle then applies round-to-nearest-even.
// Valid/ready handshakes on both sides let the surrounding pipeline stall.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_int carries an operand
//   in_ready   block can accept an operand (state is IDLE)
//   in_int     32-bit integer operand, sampled only on the accepting edge
//   out_valid  out_float holds a finished result (state is DONE)
//   out_ready  consumer takes the result
//   out_float  registered IEEE-754 single result
//   busy       a conversion is in progress or waiting to be consumed
//
// Parameter SIGNED: 1 treats in_int as two's complement, 0 as unsigned.

module fp_int_to_float_seq #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_int,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_float,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [31:0] float_q, float_d;

  logic        accept;
  logic        inSign;
  logic [31:0] inMag;
  logic        inZero;
  logic [22:0] mant;
  logic        roundUp;
  logic [23:0] mantSum;

  assign accept = in_valid && (state_q == IDLE);
  assign inSign = SIGNED ? in_int[31] : 1'b0;
  // The most negative value negates to itself, which is already the correct magnitude.
  assign inMag  = inSign ? (32'd0 - in_int) : in_int;
  assign inZero = (in_int == 32'd0);

  // Bit 31 of the normalised magnitude is the hidden one.
  // Below the 23 kept bits, bit 7 is the guard bit and bits 6..0 fold into sticky.
  assign mant    = mag_q[30:8];
  assign roundUp = mag_q[7] && ((|mag_q[6:0]) || mag_q[8]);
  assign mantSum = {1'b0, mant} + {23'd0, roundUp};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = inZero ? DONE : NORM;
      NORM:  if (mag_q[31]) state_d = ROUND;
      ROUND: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Datapath next values: load on accept, shift while normalising, pack on round
  always_comb begin
    mag_d   = mag_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    float_d = float_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = inSign;
          mag_d  = inMag;
          exp_d  = 8'd158;
          if (inZero) float_d = 32'd0;
        end
      end
      NORM: begin
        if (!mag_q[31]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      ROUND: begin
        // A mantissa carry leaves the low 23 bits at zero and bumps the exponent.
        float_d = {sign_q, exp_q + {7'd0, mantSum[23]}, mantSum[22:0]};
      end
      DONE: ;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q   <= 32'd0;
      exp_q   <= 8'd0;
      sign_q  <= 1'b0;
      float_q <= 32'd0;
    end else begin
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      float_q <= float_d;
    end
  end

  assign out_float = float_q;

endmodule

// File: tb/tb_fp_int_to_float_seq.sv
// tb_fp_int_to_float_seq
// Directed testbench for fp_int_to_float_seq.
// Two instances are used: one signed and one unsigned.
// A select line routes the shared stimulus to one instance and its outputs back.
// Expected floats and latencies were worked out by hand from the normalise/round rules.

module tb_fp_int_to_float_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic        outReady;
  logic        selUnsigned;
  logic [31:0] inInt;

  logic        inValidS, inValidU;
  logic        inReadyS, inReadyU;
  logic        outValidS, outValidU;
  logic        busyS, busyU;
  logic [31:0] outFloatS, outFloatU;

  logic        inReady, outValid, busy;
  logic [31:0] outFloat;

  int compareCount = 0;
  int failCount = 0;

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Route stimulus to the selected instance and bring its outputs back
  assign inValidS = inValid & ~selUnsigned;
  assign inValidU = inValid & selUnsigned;
  assign inReady  = selUnsigned ? inReadyU  : inReadyS;
  assign outValid = selUnsigned ? outValidU : outValidS;
  assign busy     = selUnsigned ? busyU     : busyS;
  assign outFloat = selUnsigned ? outFloatU : outFloatS;

  fp_int_to_float_seq #(.SIGNED(1'b1)) dutSigned (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValidS),
    .in_ready  (inReadyS),
    .in_int    (inInt),
    .out_valid (outValidS),
    .out_ready (outReady),
    .out_float (outFloatS),
    .busy      (busyS)
  );

  fp_int_to_float_seq #(.SIGNED(1'b0)) dutUnsigned (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValidU),
    .in_ready  (inReadyU),
    .in_int    (inInt),
    .out_valid (outValidU),
    .out_ready (outReady),
    .out_float (outFloatU),
    .busy      (busyU)
  );

  // Single comparison point: counts every check and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    compareCount++;
    if (got !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
    end
  endtask

  // Runs one conversion on the chosen instance.
  // Checks the latency, the result and the hold behaviour.
  // Also checks that the block returns to IDLE after the output handshake.
  task automatic applyStimulus(input bit useUnsigned, input logic [31:0] value,
                               input logic [31:0] expFloat, input int expLat,
                               input int holdCycles, input string tag);
    int cycles;
    logic [31:0] held;
    @(negedge clk);
    selUnsigned = useUnsigned;
    inInt       = value;
    inValid     = 1'b1;
    outReady    = 1'b0;
    #1;
    checkOutput({tag, " in_ready before"}, 32'(inReady), 32'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inInt   = 32'hDEADBEEF;
    checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
    checkOutput({tag, " in_ready after accept"}, 32'(inReady), 32'd0);
    cycles = 0;
    while (!outValid && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({tag, " latency"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, " result"}, outFloat, expFloat);
    held = outFloat;
    for (int i = 0; i < holdCycles; i++) begin
      inInt   = 32'h00001234 + 32'(i);
      inValid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput({tag, " hold out_valid"}, 32'(outValid), 32'd1);
      checkOutput({tag, " hold out_float"}, outFloat, held);
      checkOutput({tag, " hold in_ready"}, 32'(inReady), 32'd0);
    end
    outReady = 1'b1;
    if (holdCycles > 0) begin
      inValid = 1'b1;
      inInt   = 32'h00005555;
    end
    @(posedge clk);
    #1;
    outReady = 1'b0;
    inValid  = 1'b0;
    checkOutput({tag, " out_valid after take"}, 32'(outValid), 32'd0);
    checkOutput({tag, " busy after take"}, 32'(busy), 32'd0);
    checkOutput({tag, " out_float retained"}, outFloat, expFloat);
  endtask

  // Guard against a hung design
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    rst_n       = 1'b0;
    inValid     = 1'b0;
    outReady    = 1'b0;
    selUnsigned = 1'b0;
    inInt       = 32'd0;
    #12;
    checkOutput("reset out_valid", 32'(outValidS), 32'd0);
    checkOutput("reset busy", 32'(busyS), 32'd0);
    checkOutput("reset in_ready", 32'(inReadyS), 32'd1);
    checkOutput("reset out_float", outFloatS, 32'd0);
    checkOutput("reset unsigned in_ready", 32'(inReadyU), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 32'h00000001, 32'h3F800000, 33, 0, "one");
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'hBF800000, 33, 0, "minus one");
    applyStimulus(1'b0, 32'h80000000, 32'hCF000000, 2, 0, "int min signed");
    applyStimulus(1'b1, 32'h80000000, 32'h4F000000, 2, 0, "2^31 unsigned");
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'h4F800000, 2, 0, "uint max");
    applyStimulus(1'b0, 32'h7FFFFFFF, 32'h4F000000, 3, 0, "int max carry");
    applyStimulus(1'b0, 32'h01000001, 32'h4B800000, 9, 0, "tie even down");
    applyStimulus(1'b0, 32'h01000003, 32'h4B800002, 9, 0, "tie even up");
    applyStimulus(1'b0, 32'h01000005, 32'h4B800002, 9, 0, "tie even down 5");
    applyStimulus(1'b0, 32'h02000003, 32'h4C000001, 8, 0, "sticky up");
    applyStimulus(1'b0, 32'h00FFFFFF, 32'h4B7FFFFF, 10, 0, "exact 24 bits");
    applyStimulus(1'b0, 32'hFFFFFF00, 32'hC3800000, 25, 0, "minus 256");
    applyStimulus(1'b0, 32'h00000000, 32'h00000000, 0, 5, "zero hold");
    applyStimulus(1'b0, 32'h12345678, 32'h4D91A2B4, 5, 3, "pattern hold");
    applyStimulus(1'b1, 32'h00000000, 32'h00000000, 0, 0, "zero unsigned");

    // Reset in the middle of normalisation must drop the operation at once
    @(negedge clk);
    selUnsigned = 1'b0;
    inInt       = 32'h00000100;
    inValid     = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset out_valid", 32'(outValidS), 32'd0);
    checkOutput("mid reset busy", 32'(busyS), 32'd0);
    checkOutput("mid reset in_ready", 32'(inReadyS), 32'd1);
    checkOutput("mid reset out_float", outFloatS, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h00000100, 32'h43800000, 25, 0, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
